sum_request_ctrl: RTL

Initiator side of the start/done request handshake used by the sequential sum engine, which computes 1+2+...+10 = 55. On a go pulse it issues RUNS back-to-back requests. For each request it holds start until done, captures and checks the returned sum, then releases start and waits for done to drop before the next request. It also keeps pass/fail counts and flags a sticky timeout if the engine stalls. It sits between the test/control logic and the sum engine.

---
 rtl/sum_request_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/sum_request_ctrl.sv
// Initiator for the start/done handshake of the sequential sum engine: issues RUNS
// back-to-back requests per go pulse, scores each returned sum and flags engine stalls.
module sum_request_ctrl #(
    parameter int DW       = 8,
    parameter int EXPECTED = 55,
    parameter int RUNS     = 4,
    parameter int TIMEOUT  = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          go,
    input  logic          done_in,
    input  logic [DW-1:0] sum_in,
    output logic          start_out,
    output logic          busy,
    output logic [DW-1:0] result,
    output logic          result_valid,
    output logic [7:0]    pass_cnt,
    output logic [7:0]    fail_cnt,
    output logic          batch_done,
    output logic          timeout_err
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RELEASE} state_t;

    localparam logic [DW-1:0] LP_EXPECTED = DW'(EXPECTED);
    localparam logic [7:0]    LP_RUNS     = 8'(RUNS);
    localparam logic [7:0]    LP_TMO_LAST = 8'(TIMEOUT - 1);

    state_t        r_state, w_state_next;
    logic          r_start, w_start_next;
    logic          r_busy, w_busy_next;
    logic [DW-1:0] r_result, w_result_next;
    logic          r_result_valid, w_result_valid_next;
    logic [7:0]    r_pass_cnt, w_pass_cnt_next;
    logic [7:0]    r_fail_cnt, w_fail_cnt_next;
    logic          r_batch_done, w_batch_done_next;
    logic          r_timeout_err, w_timeout_err_next;
    logic [7:0]    r_run_cnt, w_run_cnt_next;
    logic [7:0]    r_tmo_cnt, w_tmo_cnt_next;

    logic w_tmo_hit;
    assign w_tmo_hit = (r_tmo_cnt == LP_TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_start        <= 1'b0;
            r_busy         <= 1'b0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_pass_cnt     <= 8'd0;
            r_fail_cnt     <= 8'd0;
            r_batch_done   <= 1'b0;
            r_timeout_err  <= 1'b0;
            r_run_cnt      <= 8'd0;
            r_tmo_cnt      <= 8'd0;
        end else begin
            r_state        <= w_state_next;
            r_start        <= w_start_next;
            r_busy         <= w_busy_next;
            r_result       <= w_result_next;
            r_result_valid <= w_result_valid_next;
            r_pass_cnt     <= w_pass_cnt_next;
            r_fail_cnt     <= w_fail_cnt_next;
            r_batch_done   <= w_batch_done_next;
            r_timeout_err  <= w_timeout_err_next;
            r_run_cnt      <= w_run_cnt_next;
            r_tmo_cnt      <= w_tmo_cnt_next;
        end
    end

    // A sampled done always beats a timeout firing on the same edge.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:    if (go && !done_in) w_state_next = S_REQ;
            S_REQ:     if (done_in || w_tmo_hit) w_state_next = done_in ? S_RELEASE : S_IDLE;
            S_RELEASE: begin
                if (!done_in)
                    w_state_next = (r_run_cnt < LP_RUNS) ? S_REQ : S_IDLE;
                else if (w_tmo_hit)
                    w_state_next = S_IDLE;
            end
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_start_next        = r_start;
        w_busy_next         = r_busy;
        w_result_next       = r_result;
        w_result_valid_next = 1'b0;
        w_pass_cnt_next     = r_pass_cnt;
        w_fail_cnt_next     = r_fail_cnt;
        w_batch_done_next   = 1'b0;
        w_timeout_err_next  = r_timeout_err;
        w_run_cnt_next      = r_run_cnt;
        w_tmo_cnt_next      = r_tmo_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (go && !done_in) begin
                    w_start_next       = 1'b1;
                    w_busy_next        = 1'b1;
                    w_run_cnt_next     = 8'd0;
                    w_tmo_cnt_next     = 8'd0;
                    w_timeout_err_next = 1'b0;
                    w_pass_cnt_next    = 8'd0;
                    w_fail_cnt_next    = 8'd0;
                end
            end
            S_REQ: begin
                if (done_in) begin
                    w_result_next       = sum_in;
                    w_result_valid_next = 1'b1;
                    w_start_next        = 1'b0;
                    if (sum_in == LP_EXPECTED) begin
                        if (r_pass_cnt != 8'hFF) w_pass_cnt_next = r_pass_cnt + 8'd1;
                    end else begin
                        if (r_fail_cnt != 8'hFF) w_fail_cnt_next = r_fail_cnt + 8'd1;
                    end
                    w_run_cnt_next = r_run_cnt + 8'd1;
                    w_tmo_cnt_next = 8'd0;
                end else if (w_tmo_hit) begin
                    w_timeout_err_next = 1'b1;
                    w_start_next       = 1'b0;
                    w_busy_next        = 1'b0;
                    w_batch_done_next  = 1'b1;
                end else begin
                    w_tmo_cnt_next = r_tmo_cnt + 8'd1;
                end
            end
            S_RELEASE: begin
                if (!done_in) begin
                    if (r_run_cnt < LP_RUNS) begin
                        w_start_next   = 1'b1;
                        w_tmo_cnt_next = 8'd0;
                    end else begin
                        w_busy_next       = 1'b0;
                        w_batch_done_next = 1'b1;
                    end
                end else if (w_tmo_hit) begin
                    w_timeout_err_next = 1'b1;
                    w_busy_next        = 1'b0;
                    w_batch_done_next  = 1'b1;
                end else begin
                    w_tmo_cnt_next = r_tmo_cnt + 8'd1;
                end
            end
            default: ;
        endcase
    end

    assign start_out    = r_start;
    assign busy         = r_busy;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign pass_cnt     = r_pass_cnt;
    assign fail_cnt     = r_fail_cnt;
    assign batch_done   = r_batch_done;
    assign timeout_err  = r_timeout_err;

endmodule
